// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared timing defaults and repeat-FSM encoding
package key_conditioner_pkg;

  // Default timing at 50 MHz: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int REPEAT_DELAY_DEF    = 25000000;
  localparam int REPEAT_RATE_DEF     = 5000000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: synchronizer, debouncer, edge pulses, auto-repeat
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCNT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              rep_q, rep_d;
  logic [1:0]        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              pressed_s;
  logic              accept;

  assign pressed_s = ~sync2_q;
  assign accept    = (pressed_s != level_q) && (cnt_q == CNT_LAST);

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (pressed_s != level_q) begin
      if (accept) begin
        level_d = pressed_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = accept & pressed_s;
    rel_d   = accept & ~pressed_s;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_d && REPEAT_EN) begin
          state_d = ST_DELAY;
          rcnt_d  = '0;
        end
      end
      ST_DELAY: begin
        if (rcnt_q == DELAY_LAST) begin
          rep_d   = 1'b1;
          rcnt_d  = '0;
          state_d = ST_REPEAT;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (rcnt_q == RATE_LAST) begin
          rep_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end
    endcase
    // Release wins over a repeat tick falling due in the same cycle
    if (rel_d) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
      rep_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign repeat_o  = rep_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N_KEYS independent active-low push-button conditioners
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int                N_KEYS          = 3,
  parameter int                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int                REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int                REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter logic [N_KEYS-1:0] REPEAT_EN       = 3'b110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_EN[g])
    ) u_key_channel (
      .clk_i     (clk),
      .rst_i     (rst),
      .key_n_i   (key_n[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g]),
      .repeat_o  (key_repeat[g])
    );
  end

endmodule
